prf_free_fifo: RTL and testbench

- Circular free-list FIFO of integer physical register indices, sitting between rename (allocation side) and commit (release side).
- Rename pops up to PRF_INT_WAYS free PRF indices per cycle. Commit pushes back the previous mappings of retiring instructions, up to PRF_INT_WAYS per cycle.
- A retired-head pointer lets a mispredict recovery reclaim all speculatively allocated registers in one cycle.

---
 rtl/prf_free_fifo.sv | 109 ++++++++++
 tb/tb_prf_free_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/prf_free_fifo.sv
// Circular free list of integer PRF indices between rename (pop) and commit (push).
// Ports: clock/reset, recover, inst_req/PRF/allocatable/alloc_fire, commit_valid/commit_old_prf, free_count, overflow_err.
module prf_free_fifo #(
  parameter int WAYS     = 4,
  parameter int PRF_SIZE = 64,
  parameter int ARF_SIZE = 32,
  parameter int IDX_W    = 6,
  parameter int DEPTH    = PRF_SIZE - ARF_SIZE,
  parameter int PTR_W    = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  recover,
  input  logic [WAYS-1:0]       inst_req,
  output logic [WAYS*IDX_W-1:0] PRF,
  output logic                  allocatable,
  output logic                  alloc_fire,
  input  logic [WAYS-1:0]       commit_valid,
  input  logic [WAYS*IDX_W-1:0] commit_old_prf,
  output logic [PTR_W-1:0]      free_count,
  output logic                  overflow_err
);

  localparam int AW = PTR_W - 1;
  localparam int CW = $clog2(WAYS + 1);
  localparam logic [PTR_W:0] DEPTH_W = (PTR_W+1)'(DEPTH);

  logic [IDX_W-1:0] fifo_q [DEPTH];
  logic [IDX_W-1:0] fifo_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] rhead_q, rhead_d;
  logic             ovf_q, ovf_d;

  logic [CW-1:0]    n_req, n_com;
  logic [CW-1:0]    req_off [WAYS];
  logic [CW-1:0]    com_off [WAYS];
  logic [AW-1:0]    rd_idx  [WAYS];
  logic [AW-1:0]    wr_idx  [WAYS];
  logic [CW-1:0]    n_pop;
  logic [PTR_W:0]   free_after;

  // Way compaction: each way's offset is the count of set bits below it.
  always_comb begin
    n_req = '0;
    n_com = '0;
    for (int i = 0; i < WAYS; i++) begin
      req_off[i] = n_req;
      com_off[i] = n_com;
      n_req = n_req + CW'(inst_req[i]);
      n_com = n_com + CW'(commit_valid[i]);
    end
  end

  always_comb begin
    free_count  = tail_q - head_q;
    allocatable = (free_count >= PTR_W'(n_req)) & ~recover;
    alloc_fire  = allocatable & (|inst_req);
    PRF = '0;
    for (int i = 0; i < WAYS; i++) begin
      rd_idx[i] = AW'(head_q + PTR_W'(req_off[i]));
      wr_idx[i] = AW'(tail_q + PTR_W'(com_off[i]));
      PRF[i*IDX_W +: IDX_W] = fifo_q[rd_idx[i]];
    end
  end

  always_comb begin
    fifo_d = fifo_q;
    for (int i = 0; i < WAYS; i++) begin
      if (commit_valid[i]) begin
        fifo_d[wr_idx[i]] = commit_old_prf[i*IDX_W +: IDX_W];
      end
    end
    tail_d  = tail_q + PTR_W'(n_com);
    rhead_d = rhead_q + PTR_W'(n_com);
    head_d  = head_q;
    if (recover) begin
      // Same-cycle commits retire before the speculative head is rolled back.
      head_d = rhead_q + PTR_W'(n_com);
    end else if (alloc_fire) begin
      head_d = head_q + PTR_W'(n_req);
    end
    n_pop      = alloc_fire ? n_req : '0;
    free_after = {1'b0, free_count} - (PTR_W+1)'(n_pop)
               + (PTR_W+1)'(n_com);
    ovf_d      = ovf_q | (free_after > DEPTH_W);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        fifo_q[k] <= IDX_W'(ARF_SIZE + k);
      end
      head_q  <= '0;
      rhead_q <= '0;
      tail_q  <= PTR_W'(DEPTH);
      ovf_q   <= 1'b0;
    end else begin
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      rhead_q <= rhead_d;
      tail_q  <= tail_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_prf_free_fifo.sv
// Scoreboard bench for prf_free_fifo: directed stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_prf_free_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        recover;
  logic [3:0]  inst_req;
  logic [23:0] PRF;
  logic        allocatable;
  logic        alloc_fire;
  logic [3:0]  commit_valid;
  logic [23:0] commit_old_prf;
  logic [5:0]  free_count;
  logic        overflow_err;

  prf_free_fifo dut (
    .clock          (clock),
    .reset          (reset),
    .recover        (recover),
    .inst_req       (inst_req),
    .PRF            (PRF),
    .allocatable    (allocatable),
    .alloc_fire     (alloc_fire),
    .commit_valid   (commit_valid),
    .commit_old_prf (commit_old_prf),
    .free_count     (free_count),
    .overflow_err   (overflow_err)
  );

  always #5 clock = ~clock;

  typedef enum {K_ALLOC, K_FIRE, K_FREE, K_OVF,
                K_PRF0, K_PRF1, K_PRF2, K_PRF3} kind_e;
  typedef struct {
    int    cyc;
    kind_e k;
    int    v;
  } exp_t;

  exp_t sbq[$];
  int   cyc_n  = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc_n <= cyc_n + 1;

  function automatic int get_out(input kind_e k);
    case (k)
      K_ALLOC: return int'(allocatable);
      K_FIRE:  return int'(alloc_fire);
      K_FREE:  return int'(free_count);
      K_OVF:   return int'(overflow_err);
      K_PRF0:  return int'(PRF[5:0]);
      K_PRF1:  return int'(PRF[11:6]);
      K_PRF2:  return int'(PRF[17:12]);
      default: return int'(PRF[23:18]);
    endcase
  endfunction

  // Monitor: consumes every expectation queued for the current cycle.
  always @(negedge clock) begin
    while (sbq.size() > 0 && sbq[0].cyc == cyc_n) begin
      exp_t e;
      int   act;
      e   = sbq.pop_front();
      act = get_out(e.k);
      checks++;
      if (act != e.v) begin
        errors++;
        $display("FAIL %s cyc %0d: got %0d expected %0d",
                 e.k.name(), e.cyc, act, e.v);
      end
    end
  end

  task automatic drv(input logic [3:0] rq, input logic rc,
                     input logic [3:0] cv, input int o0, input int o1,
                     input int o2, input int o3);
    @(posedge clock);
    #1;
    reset          = 1'b0;
    recover        = rc;
    inst_req       = rq;
    commit_valid   = cv;
    commit_old_prf = {6'(o3), 6'(o2), 6'(o1), 6'(o0)};
  endtask

  task automatic idle();
    drv(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset          = 1'b1;
    recover        = 1'b0;
    inst_req       = '0;
    commit_valid   = '0;
    commit_old_prf = '0;
  endtask

  task automatic ex(input kind_e k, input int v);
    sbq.push_back('{cyc_n, k, v});
  endtask

  task automatic ex_prf(input int p0, input int p1,
                        input int p2, input int p3);
    ex(K_PRF0, p0);
    ex(K_PRF1, p1);
    ex(K_PRF2, p2);
    ex(K_PRF3, p3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    recover        = 1'b0;
    inst_req       = '0;
    commit_valid   = '0;
    commit_old_prf = '0;
    do_reset();

    // Reset state and a full-width allocation.
    idle();
    ex(K_FREE, 32); ex(K_ALLOC, 1); ex(K_FIRE, 0); ex(K_OVF, 0);
    drv(4'b1111, 1'b0, 4'b0000, 0, 0, 0, 0);
    ex(K_ALLOC, 1); ex(K_FIRE, 1); ex_prf(32, 33, 34, 35);
    // Sparse request compacts onto consecutive entries.
    drv(4'b1010, 1'b0, 4'b0000, 0, 0, 0, 0);
    ex(K_FREE, 28); ex(K_FIRE, 1); ex(K_PRF1, 36); ex(K_PRF3, 37);
    idle();
    ex(K_FREE, 26);

    // Drain to empty, stall, then a single commit refills through index 0.
    do_reset();
    idle();
    ex(K_FREE, 32);
    for (int c = 0; c < 8; c++) begin
      drv(4'b1111, 1'b0, 4'b0000, 0, 0, 0, 0);
      ex(K_FIRE, 1); ex(K_PRF0, 32 + 4*c);
    end
    drv(4'b0001, 1'b0, 4'b0000, 0, 0, 0, 0);
    ex(K_FREE, 0); ex(K_ALLOC, 0); ex(K_FIRE, 0);
    drv(4'b0001, 1'b0, 4'b0001, 5, 0, 0, 0);
    ex(K_ALLOC, 0); ex(K_FREE, 0);
    drv(4'b0001, 1'b0, 4'b0000, 0, 0, 0, 0);
    ex(K_ALLOC, 1); ex(K_FIRE, 1); ex(K_FREE, 1); ex(K_PRF0, 5);
    idle();
    ex(K_FREE, 0);

    // Recovery: 12 allocated, 4 retired, then recover with 2 more retiring.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drv(4'b1111, 1'b0, 4'b0000, 0, 0, 0, 0);
      ex_prf(32 + 4*c, 33 + 4*c, 34 + 4*c, 35 + 4*c);
    end
    drv(4'b0000, 1'b0, 4'b1111, 0, 1, 2, 3);
    ex(K_FREE, 20);
    drv(4'b1111, 1'b1, 4'b0011, 4, 5, 0, 0);
    ex(K_ALLOC, 0); ex(K_FIRE, 0); ex(K_FREE, 24);
    idle();
    ex(K_FREE, 32); ex(K_ALLOC, 1);
    // Head rolled back to entry 6, which still holds its reset value 38.
    drv(4'b0001, 1'b0, 4'b0000, 0, 0, 0, 0);
    ex(K_PRF0, 38); ex(K_FIRE, 1);

    // Simultaneous pop and push at free_count=4, no bypass.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drv(4'b1111, 1'b0, 4'b0000, 0, 0, 0, 0);
    end
    drv(4'b1111, 1'b0, 4'b1111, 10, 11, 12, 13);
    ex(K_FREE, 4); ex(K_FIRE, 1); ex_prf(60, 61, 62, 63);
    drv(4'b1111, 1'b0, 4'b0000, 0, 0, 0, 0);
    ex(K_FREE, 4); ex(K_FIRE, 1); ex_prf(10, 11, 12, 13);
    idle();
    ex(K_FREE, 0);

    // Overflow: push 2 with 31 free, sticky until reset.
    do_reset();
    drv(4'b0001, 1'b0, 4'b0000, 0, 0, 0, 0);
    ex(K_PRF0, 32); ex(K_FREE, 32);
    drv(4'b0000, 1'b0, 4'b0011, 7, 8, 0, 0);
    ex(K_FREE, 31); ex(K_OVF, 0);
    idle();
    ex(K_OVF, 1); ex(K_FREE, 33);
    idle();
    ex(K_OVF, 1);
    do_reset();
    idle();
    ex(K_OVF, 0); ex(K_FREE, 32); ex(K_ALLOC, 1);
    drv(4'b0001, 1'b0, 4'b0000, 0, 0, 0, 0);
    ex(K_PRF0, 32);

    idle();
    idle();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sbq_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
